// File: rtl/clk_glitch_monitor.sv
// Oversampling checker for a monitored clock: pulse widths, runt pulses and stuck detection.
// Defining CLK_GLITCH_MONITOR_MINMAX_EN adds min_hi_width / min_lo_width tracking outputs.
module clk_glitch_monitor #(
    parameter int CNT_W       = 8,
    parameter int MIN_HIGH    = 2,
    parameter int MIN_LOW     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_in,
    input  logic             en,
    input  logic             clr,
    output logic             glitch,
    output logic             glitch_sticky,
    output logic [7:0]       glitch_cnt,
    output logic             stuck,
    output logic [CNT_W-1:0] hi_width,
    output logic [CNT_W-1:0] lo_width,
    output logic             width_valid
`ifdef CLK_GLITCH_MONITOR_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_hi_width,
    output logic [CNT_W-1:0] min_lo_width
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_HI_V  = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MIN_LO_V  = CNT_W'(MIN_LOW);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc_w(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic                   s_s;
    logic                   edge_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   glitch_r;
    logic                   glitch_sticky_r;
    logic [7:0]             glitch_cnt_r;
    logic                   stuck_r;
    logic [CNT_W-1:0]       hi_width_r;
    logic [CNT_W-1:0]       lo_width_r;
    logic                   width_valid_r;

    // Synchronized level and edge strobe
    always_comb begin
        s_s    = sync_r[SYNC_STAGES-1];
        edge_s = s_s ^ s_d_r;
    end

    // Synchronizer chain plus one delay flop; keeps running while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], mon_in};
            s_d_r  <= s_s;
        end
    end

    // Measurement FSM, level counter and registered reporting outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= WAIT_EDGE;
            cnt_r         <= CNT_ZERO;
            glitch_r      <= 1'b0;
            stuck_r       <= 1'b0;
            hi_width_r    <= CNT_ZERO;
            lo_width_r    <= CNT_ZERO;
            width_valid_r <= 1'b0;
        end else if (!en) begin
            state_r       <= WAIT_EDGE;
            cnt_r         <= CNT_ZERO;
            glitch_r      <= 1'b0;
            stuck_r       <= 1'b0;
            width_valid_r <= 1'b0;
        end else begin
            glitch_r      <= 1'b0;
            width_valid_r <= 1'b0;
            cnt_r         <= edge_s ? CNT_ONE : sat_inc_w(cnt_r);
            case (state_r)
                WAIT_EDGE: begin
                    stuck_r <= 1'b0;
                    if (edge_s) begin
                        state_r <= s_s ? MEAS_HIGH : MEAS_LOW;
                    end
                end
                MEAS_HIGH: begin
                    if (edge_s) begin
                        hi_width_r    <= cnt_r;
                        width_valid_r <= 1'b1;
                        glitch_r      <= (cnt_r < MIN_HI_V);
                        stuck_r       <= 1'b0;
                        state_r       <= MEAS_LOW;
                    end else if (cnt_r == TIMEOUT_V) begin
                        stuck_r <= 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (edge_s) begin
                        lo_width_r    <= cnt_r;
                        width_valid_r <= 1'b1;
                        glitch_r      <= (cnt_r < MIN_LO_V);
                        stuck_r       <= 1'b0;
                        state_r       <= MEAS_HIGH;
                    end else if (cnt_r == TIMEOUT_V) begin
                        stuck_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= WAIT_EDGE;
                    stuck_r <= 1'b0;
                end
            endcase
        end
    end

    // Glitch accounting follows the visible glitch pulse; a glitch beats a coincident clr
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_sticky_r <= 1'b0;
            glitch_cnt_r    <= 8'd0;
        end else if (glitch_r) begin
            glitch_sticky_r <= 1'b1;
            glitch_cnt_r    <= clr ? 8'd1 : sat_inc_8(glitch_cnt_r);
        end else if (clr) begin
            glitch_sticky_r <= 1'b0;
            glitch_cnt_r    <= 8'd0;
        end
    end

    assign glitch        = glitch_r;
    assign glitch_sticky = glitch_sticky_r;
    assign glitch_cnt    = glitch_cnt_r;
    assign stuck         = stuck_r;
    assign hi_width      = hi_width_r;
    assign lo_width      = lo_width_r;
    assign width_valid   = width_valid_r;

`ifdef CLK_GLITCH_MONITOR_MINMAX_EN
    logic             kind_hi_r;
    logic [CNT_W-1:0] min_hi_r;
    logic [CNT_W-1:0] min_lo_r;

    function automatic logic [CNT_W-1:0] min_w(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    // Remembers which width the current width_valid pulse refers to
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_hi_r <= 1'b0;
        end else if (en && edge_s && (state_r == MEAS_HIGH)) begin
            kind_hi_r <= 1'b1;
        end else if (en && edge_s && (state_r == MEAS_LOW)) begin
            kind_hi_r <= 1'b0;
        end
    end

    // Running minimum widths; a fresh width beats a coincident clr
    always_ff @(posedge clk) begin
        if (rst) begin
            min_hi_r <= CNT_MAX;
            min_lo_r <= CNT_MAX;
        end else if (width_valid_r) begin
            if (kind_hi_r) begin
                min_hi_r <= clr ? hi_width_r : min_w(min_hi_r, hi_width_r);
                if (clr) begin
                    min_lo_r <= CNT_MAX;
                end
            end else begin
                min_lo_r <= clr ? lo_width_r : min_w(min_lo_r, lo_width_r);
                if (clr) begin
                    min_hi_r <= CNT_MAX;
                end
            end
        end else if (clr) begin
            min_hi_r <= CNT_MAX;
            min_lo_r <= CNT_MAX;
        end
    end

    assign min_hi_width = min_hi_r;
    assign min_lo_width = min_lo_r;
`endif

endmodule

// File: tb/tb_clk_glitch_monitor.sv
// Self-checking bench for clk_glitch_monitor: timestamp-based reference model, vector table,
// directed corner sequences and randomized pulse trains.
`timescale 1ns/1ps
module tb_clk_glitch_monitor;
    localparam int CNT_W    = 8;
    localparam int MIN_HIGH = 2;
    localparam int MIN_LOW  = 2;
    localparam int SYNC     = 2;
    localparam int TIMEOUT  = 64;
    localparam int WMAX     = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_in = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic glitch, glitch_sticky, stuck, width_valid;
    logic [7:0] glitch_cnt;
    logic [CNT_W-1:0] hi_width, lo_width;
`ifdef CLK_GLITCH_MONITOR_MINMAX_EN
    logic [CNT_W-1:0] min_hi_width, min_lo_width;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #1 clk = ~clk;

    clk_glitch_monitor #(
        .CNT_W(CNT_W), .MIN_HIGH(MIN_HIGH), .MIN_LOW(MIN_LOW),
        .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .mon_in(mon_in), .en(en), .clr(clr),
        .glitch(glitch), .glitch_sticky(glitch_sticky), .glitch_cnt(glitch_cnt),
        .stuck(stuck), .hi_width(hi_width), .lo_width(lo_width), .width_valid(width_valid)
`ifdef CLK_GLITCH_MONITOR_MINMAX_EN
        , .min_hi_width(min_hi_width), .min_lo_width(min_lo_width)
`endif
    );

    // Reference model: mon_in samples delayed through the synchronizer, edges time-stamped.
    bit mq[$];
    int k = 0;
    int last_edge_k = 0;
    bit armed = 1'b0;
    bit e_gl = 1'b0, e_wv = 1'b0, e_sticky = 1'b0, e_stuck = 1'b0, e_kind_hi = 1'b0;
    int e_gcnt = 0, e_hi = 0, e_lo = 0, e_min_hi = WMAX, e_min_lo = WMAX;

    // Observation bookkeeping for the directed checks
    int gl_seen = 0, wv_seen = 0, last_wv_k = 0, stuck_rise_k = 0;
    bit prev_stuck = 1'b0;
    bit cur_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tick %0d)", nm, act, exp, k);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit c, input bit m);
        bit s_pre, sd_pre, is_edge, new_gl, new_wv;
        int w, nw;
        k++;
        if (r) begin
            mq.delete();
            for (int i = 0; i <= SYNC; i++) mq.push_back(1'b0);
            armed = 1'b0; e_gl = 1'b0; e_wv = 1'b0; e_sticky = 1'b0; e_stuck = 1'b0;
            e_gcnt = 0; e_hi = 0; e_lo = 0; e_kind_hi = 1'b0;
            e_min_hi = WMAX; e_min_lo = WMAX;
            return;
        end
        s_pre   = mq[SYNC-1];
        sd_pre  = mq[SYNC];
        is_edge = (s_pre != sd_pre);
        mq.push_front(m);
        void'(mq.pop_back());
        if (e_gl) begin
            e_sticky = 1'b1;
            e_gcnt   = c ? 1 : imin(e_gcnt + 1, 255);
        end else if (c) begin
            e_sticky = 1'b0;
            e_gcnt   = 0;
        end
        if (e_wv) begin
            nw = e_kind_hi ? e_hi : e_lo;
            if (e_kind_hi) begin
                e_min_hi = c ? nw : imin(e_min_hi, nw);
                if (c) e_min_lo = WMAX;
            end else begin
                e_min_lo = c ? nw : imin(e_min_lo, nw);
                if (c) e_min_hi = WMAX;
            end
        end else if (c) begin
            e_min_hi = WMAX;
            e_min_lo = WMAX;
        end
        new_gl = 1'b0;
        new_wv = 1'b0;
        if (!e) begin
            armed   = 1'b0;
            e_stuck = 1'b0;
        end else if (is_edge) begin
            if (armed) begin
                w = imin(k - last_edge_k, WMAX);
                new_wv = 1'b1;
                if (sd_pre) begin
                    e_hi = w; new_gl = (w < MIN_HIGH); e_kind_hi = 1'b1;
                end else begin
                    e_lo = w; new_gl = (w < MIN_LOW); e_kind_hi = 1'b0;
                end
            end
            armed       = 1'b1;
            last_edge_k = k;
            e_stuck     = 1'b0;
        end else if (armed && (k - last_edge_k) >= TIMEOUT) begin
            e_stuck = 1'b1;
        end
        e_gl = new_gl;
        e_wv = new_wv;
    endtask

    // One clk cycle: drive at negedge, model at posedge, compare at the following negedge
    task automatic tick(input bit r, input bit e, input bit c, input bit m);
        rst = r; en = e; clr = c; mon_in = m;
        @(posedge clk);
        model_step(r, e, c, m);
        @(negedge clk);
        chk("glitch", glitch, e_gl);
        chk("width_valid", width_valid, e_wv);
        chk("glitch_sticky", glitch_sticky, e_sticky);
        chk("glitch_cnt", glitch_cnt, e_gcnt);
        chk("stuck", stuck, e_stuck);
        chk("hi_width", hi_width, e_hi);
        chk("lo_width", lo_width, e_lo);
`ifdef CLK_GLITCH_MONITOR_MINMAX_EN
        chk("min_hi_width", min_hi_width, e_min_hi);
        chk("min_lo_width", min_lo_width, e_min_lo);
`endif
        if (glitch === 1'b1) gl_seen++;
        if (width_valid === 1'b1) begin
            wv_seen++;
            last_wv_k = k;
        end
        if (stuck === 1'b1 && !prev_stuck) stuck_rise_k = k;
        prev_stuck = (stuck === 1'b1);
    endtask

    task automatic lvl(input bit m, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, cur_en, 1'b0, m);
    endtask

    task automatic pulses(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            lvl(1'b1, hi);
            lvl(1'b0, lo);
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_hi;
        int exp_lo;
        int exp_gl;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5, 5, 5, 5, 0};
        vecs[1] = '{2, 2, 2, 2, 0};
        vecs[2] = '{1, 3, 1, 3, 1};
        vecs[3] = '{3, 1, 3, 1, 1};
        vecs[4] = '{1, 1, 1, 1, 2};
        vecs[5] = '{7, 2, 7, 2, 0};
        vecs[6] = '{2, 1, 2, 1, 1};
        vecs[7] = '{4, 9, 4, 9, 0};

        @(negedge clk);
        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_glitch_cnt", glitch_cnt, 0);
        chk("rst_hi_width", hi_width, 0);
        chk("rst_stuck", stuck, 0);
        cur_en = 1'b1;

        // 20 ns clock: 5-cycle levels
        lvl(1'b0, 3);
        gl_seen = 0; wv_seen = 0;
        pulses(5, 5, 8);
        chk("p20_hi", hi_width, 5);
        chk("p20_lo", lo_width, 5);
        chk("p20_wv_count", wv_seen, 15);
        chk("p20_no_glitch", gl_seen, 0);
        chk("p20_stuck", stuck, 0);

        // Clean switch to an 8 ns clock during the low phase
        gl_seen = 0;
        pulses(2, 2, 6);
        chk("p8_hi", hi_width, 2);
        chk("p8_lo", lo_width, 2);
        chk("p8_no_glitch", gl_seen, 0);
`ifdef CLK_GLITCH_MONITOR_MINMAX_EN
        chk("p8_min_hi", min_hi_width, 2);
`endif

        // Single high runt during a low phase, then clr
        lvl(1'b0, 6);
        gl_seen = 0;
        lvl(1'b1, 1);
        lvl(1'b0, 6);
        chk("runt_pulses", gl_seen, 1);
        chk("runt_hi", hi_width, 1);
        chk("runt_sticky", glitch_sticky, 1);
        chk("runt_cnt", glitch_cnt, 1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        lvl(1'b0, 1);
        chk("clr_sticky", glitch_sticky, 0);
        chk("clr_cnt", glitch_cnt, 0);

        // Stopped clock: stuck exactly TIMEOUT cycles after the last report
        lvl(1'b1, 4);
        lvl(1'b0, 100);
        chk("stuck_set", stuck, 1);
        chk("stuck_delay", stuck_rise_k - last_wv_k, TIMEOUT);
        gl_seen = 0;
        lvl(1'b1, 4);
        chk("stuck_clear", stuck, 0);
        chk("stuck_lo_long", (lo_width >= TIMEOUT) ? 1 : 0, 1);
        chk("stuck_no_glitch", gl_seen, 0);
        lvl(1'b0, 300);
        lvl(1'b1, 4);
        chk("sat_lo", lo_width, WMAX);

        // 300 runts saturate the count; clr coinciding with a glitch pulse
        lvl(1'b0, 4);
        for (int i = 0; i < 300; i++) begin
            lvl(1'b1, 1);
            lvl(1'b0, 2);
        end
        lvl(1'b0, 6);
        chk("sat_cnt", glitch_cnt, 255);
        lvl(1'b1, 1);
        gl_seen = 0;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, e_gl, 1'b0);
        chk("clr_vs_glitch_seen", gl_seen, 1);
        chk("clr_vs_glitch_cnt", glitch_cnt, 1);
        chk("clr_vs_glitch_sticky", glitch_sticky, 1);

        // en low for 50 ns, then rst mid-high
        pulses(5, 5, 2);
        cur_en = 1'b0;
        gl_seen = 0; wv_seen = 0;
        for (int i = 0; i < 5; i++) begin
            lvl(1'b1, 1);
            lvl(1'b0, 3);
        end
        lvl(1'b1, 5);
        chk("en_low_wv", wv_seen, 0);
        chk("en_low_glitch", gl_seen, 0);
        chk("en_low_hold_cnt", glitch_cnt, 1);
        cur_en = 1'b1;
        lvl(1'b0, 5);
        lvl(1'b1, 3);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst2_hi", hi_width, 0);
        chk("rst2_lo", lo_width, 0);
        chk("rst2_sticky", glitch_sticky, 0);
        wv_seen = 0;
        lvl(1'b0, 3);
        lvl(1'b1, 4);
        chk("rst2_partial_dropped", wv_seen, 0);
        lvl(1'b0, 5);
        lvl(1'b1, 5);
        chk("rst2_first_hi", hi_width, 4);

        // Vector table
        lvl(1'b0, 6);
        for (int v = 0; v < 8; v++) begin
            gl_seen = 0;
            lvl(1'b1, vecs[v].hi);
            lvl(1'b0, vecs[v].lo);
            lvl(1'b1, SYNC + 3);
            chk($sformatf("vec%0d_hi", v), hi_width, vecs[v].exp_hi);
            chk($sformatf("vec%0d_lo", v), lo_width, vecs[v].exp_lo);
            chk($sformatf("vec%0d_glitches", v), gl_seen, vecs[v].exp_gl);
            lvl(1'b0, 6);
        end

        // Randomized pulse trains with occasional en drops, clr and rst
        for (int seg = 0; seg < 500; seg++) begin
            int n;
            bit lv;
            lv = seg[0];
            if ($urandom_range(0, 14) == 0) cur_en = ~cur_en;
            n = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                tick(($urandom_range(0, 399) == 0), cur_en, ($urandom_range(0, 19) == 0), lv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
